// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor (package add_sub_pkg).
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

  // Bits needed to count 0..value-1; callers clamp the result to at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub; the master drives operands, the slave returns results.
interface serial_add_sub_if #(
  parameter int WIDTH = 16
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds its payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb;
  logic             ovf;

  modport master (
    output in_valid, a, b, ctrl, out_ready,
    input  in_ready, out_valid, result, cb, ovf
  );

  modport slave (
    input  in_valid, a, b, ctrl, out_ready,
    output in_ready, out_valid, result, cb, ovf
  );
endinterface

// File: rtl/serial_add_sub_digit.sv
// Combinational DIGIT-bit ripple-carry slice (module add_sub_digit) shared by every serial step.
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout     = c[DIGIT];
    c_msb_in = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH/DIGIT cycles per operation through one ripple slice.
// Define ADD_SUB_SAT_EN to saturate the result to the signed limit on overflow.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_sub_if.slave  bus,
  output state_e           dbg_state
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_add_sub: DIGIT=%0d must divide WIDTH=%0d", DIGIT, WIDTH);
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               ctrl_q, ctrl_d;
  logic               cb_q, cb_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_cout;
  logic               dig_cmsb;
  logic [WIDTH-1:0]   res_shift;
  logic [WIDTH-1:0]   res_final;

  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // New digits enter at the top, so after NDIG steps the least significant digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign res_shift = dig_s;
  end else begin : g_multi_digit
    assign res_shift = {dig_s, res_q[WIDTH-1:DIGIT]};
  end

`ifdef ADD_SUB_SAT_EN
  logic a_sign_q, a_sign_d;
  logic [WIDTH-1:0] sat_val;

  assign sat_val   = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign res_final = (dig_cmsb ^ dig_cout) ? sat_val : res_shift;

  always_ff @(posedge clk) begin
    if (rst) a_sign_q <= 1'b0;
    else     a_sign_q <= a_sign_d;
  end

  always_comb begin
    a_sign_d = a_sign_q;
    if (state_q == IDLE && bus.in_valid) a_sign_d = bus.a[WIDTH-1];
  end
`else
  assign res_final = res_shift;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ctrl_q  <= CTRL_ADD;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ctrl_q  <= ctrl_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ctrl_d  = ctrl_q;
    cb_d    = cb_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: invert B here, the +1 rides in as the initial carry.
          a_d     = bus.a;
          b_d     = (bus.ctrl == CTRL_SUB) ? ~bus.b : bus.b;
          carry_d = bus.ctrl;
          ctrl_d  = bus.ctrl;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIG) begin
          res_d   = res_final;
          cb_d    = (ctrl_q == CTRL_SUB) ? ~dig_cout : dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = res_q;
    bus.cb        = cb_q;
    bus.ovf       = ovf_q;
    dbg_state     = state_q;
  end

endmodule
